// File: rtl/fp_seq_pkg.sv
// Shared types and helpers for the F-PM microoperation sequencer: phase numbering,
// operation classes, strobe substates and the per-class phase path.
package fp_seq_pkg;

    typedef logic [3:0] phase_t;

    localparam phase_t F_NONE = 4'd0;
    localparam phase_t F1     = 4'd1;
    localparam phase_t F2     = 4'd2;
    localparam phase_t F3     = 4'd3;
    localparam phase_t F4     = 4'd4;
    localparam phase_t F5     = 4'd5;
    localparam phase_t F6     = 4'd6;
    localparam phase_t F7     = 4'd7;
    localparam phase_t F8     = 4'd8;
    localparam phase_t F9     = 4'd9;
    localparam phase_t F10    = 4'd10;
    localparam phase_t F11    = 4'd11;
    localparam phase_t F12    = 4'd12;
    localparam phase_t F13    = 4'd13;

    typedef enum logic [2:0] {C_NRF, C_ADSD, C_MWDW, C_AFSF, C_MFDF} op_class_t;

    typedef enum logic [2:0] {S_ENTER, S_STROB, S_GAP, S_STROB2, S_DECIDE} substate_t;

    // Straight-line successor of a phase; F_NONE marks the end of the path.
    function automatic phase_t next_phase(input op_class_t cls, input phase_t ph);
        phase_t nxt;
        nxt = F_NONE;
        case (cls)
            C_ADSD: case (ph)
                F1:      nxt = F7;
                F7:      nxt = F10;
                default: nxt = F_NONE;
            endcase
            C_MWDW: case (ph)
                F1:      nxt = F2;
                F2:      nxt = F4;
                F4:      nxt = F6;
                F6:      nxt = F7;
                F7:      nxt = F10;
                default: nxt = F_NONE;
            endcase
            C_AFSF: case (ph)
                F1:      nxt = F2;
                F2:      nxt = F4;
                F4:      nxt = F5;
                F5:      nxt = F8;
                F8:      nxt = F9;
                F9:      nxt = F10;
                F10:     nxt = F13;
                default: nxt = F_NONE;
            endcase
            C_MFDF: case (ph)
                F1:      nxt = F2;
                F2:      nxt = F4;
                F4:      nxt = F6;
                F6:      nxt = F7;
                F7:      nxt = F8;
                F8:      nxt = F9;
                F9:      nxt = F10;
                F10:     nxt = F13;
                default: nxt = F_NONE;
            endcase
            default: case (ph)
                F1:      nxt = F8;
                F8:      nxt = F10;
                F10:     nxt = F13;
                default: nxt = F_NONE;
            endcase
        endcase
        return nxt;
    endfunction

    // nrf wins; otherwise only a fixed-point group opcode selects the AD/SD or MW/DW paths.
    function automatic op_class_t decode_class(input logic pufa, input logic nrf,
                                               input logic ir7, input logic ir8);
        op_class_t cls;
        if (nrf)
            cls = C_NRF;
        else if (pufa && !ir7)
            cls = ir8 ? C_MWDW : C_ADSD;
        else
            cls = ir8 ? C_MFDF : C_AFSF;
        return cls;
    endfunction

    function automatic logic [1:13] phase_bits(input phase_t ph);
        logic [1:13] b;
        for (int i = 1; i <= 13; i++)
            b[i] = (ph == phase_t'(i));
        return b;
    endfunction

endpackage

// File: rtl/fp_seq_strob.sv
// Per-phase substate generator: ENTER, STROB, GAP (gap cycles), STROB2, DECIDE.
// A go pulse (re)starts the sequence; without one the generator idles after DECIDE.
module fp_strob
    import fp_seq_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       go,
    input  logic [2:0] gap,
    output logic       strob_fp_,
    output logic       strob2_fp,
    output logic       decide
);

    substate_t  sub_reg;
    logic       run_reg;
    logic [2:0] gap_cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sub_reg     <= S_ENTER;
            run_reg     <= 1'b0;
            gap_cnt_reg <= '0;
            strob_fp_   <= 1'b1;
            strob2_fp   <= 1'b0;
            decide      <= 1'b0;
        end else if (go) begin
            sub_reg     <= S_ENTER;
            run_reg     <= 1'b1;
            gap_cnt_reg <= '0;
            strob_fp_   <= 1'b1;
            strob2_fp   <= 1'b0;
            decide      <= 1'b0;
        end else if (run_reg) begin
            case (sub_reg)
                S_ENTER: begin
                    sub_reg   <= S_STROB;
                    strob_fp_ <= 1'b0;
                end
                S_STROB: begin
                    sub_reg     <= S_GAP;
                    strob_fp_   <= 1'b1;
                    gap_cnt_reg <= gap - 3'd1;
                end
                S_GAP: begin
                    if (gap_cnt_reg == 3'd0) begin
                        sub_reg   <= S_STROB2;
                        strob2_fp <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 3'd1;
                    end
                end
                S_STROB2: begin
                    sub_reg   <= S_DECIDE;
                    strob2_fp <= 1'b0;
                    decide    <= 1'b1;
                end
                default: begin
                    sub_reg <= S_ENTER;
                    run_reg <= 1'b0;
                    decide  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fp_seq.sv
// F-PM microoperation sequencer: walks the phase path of the latched class, loops F6/F8
// on F-PM status with an iteration guard, and re-enters F7 once on a rounding request.
module fp_seq
    import fp_seq_pkg::*;
#(
    parameter int STROB_GAP = 1,
    parameter int MAX_LOOP  = 48
) (
    input  logic        __clk,
    input  logic        clr_,
    input  logic        start,
    input  logic [7:9]  ir,
    input  logic        pufa,
    input  logic        nrf,
    input  logic        fic,
    input  logic        nz,
    input  logic        ws_,
    output logic [1:13] f,
    output logic        strob_fp_,
    output logic        strob2_fp,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int LW = $clog2(MAX_LOOP + 1);

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_state_t;

    top_state_t      state_reg;
    phase_t          phase_reg;
    op_class_t       class_reg;
    logic            ff_reg;
    logic            reent_reg;
    logic            err_sticky_reg;
    logic [LW-1:0]   loop_cnt_reg;

    logic   srst;
    logic   decide;
    logic   go;
    logic   loop_cond;
    logic   loop_max;
    logic   repeat_ph;
    logic   trip;
    logic   reenter;
    logic   finish;
    phase_t nxt_phase;
    logic   unused_ir9;

    assign srst       = ~clr_;
    assign unused_ir9 = ir[9];

    fp_strob u_strob (
        .clk       (__clk),
        .srst      (srst),
        .go        (go),
        .gap       (3'(STROB_GAP)),
        .strob_fp_ (strob_fp_),
        .strob2_fp (strob2_fp),
        .decide    (decide)
    );

    always_comb begin
        loop_cond = ((phase_reg == F6) && fic) || ((phase_reg == F8) && nz);
        loop_max  = (loop_cnt_reg == LW'(MAX_LOOP));
        repeat_ph = loop_cond && !loop_max;
        trip      = loop_cond && loop_max;
        reenter   = (phase_reg == F10) && ff_reg && !ws_ && !reent_reg;
        // After the single re-entry, F7 always returns straight to F10.
        if (reenter)
            nxt_phase = F7;
        else if (reent_reg && (phase_reg == F7))
            nxt_phase = F10;
        else
            nxt_phase = next_phase(class_reg, phase_reg);
        finish = !repeat_ph && (nxt_phase == F_NONE);
        go     = ((state_reg == T_IDLE) && start) ||
                 ((state_reg == T_RUN) && decide && !finish);
    end

    always_ff @(posedge __clk) begin
        if (!clr_) begin
            state_reg      <= T_IDLE;
            phase_reg      <= F_NONE;
            class_reg      <= C_NRF;
            ff_reg         <= 1'b0;
            reent_reg      <= 1'b0;
            err_sticky_reg <= 1'b0;
            loop_cnt_reg   <= '0;
            f              <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            case (state_reg)
                T_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        state_reg      <= T_RUN;
                        phase_reg      <= F1;
                        f              <= phase_bits(F1);
                        class_reg      <= decode_class(pufa, nrf, ir[7], ir[8]);
                        ff_reg         <= nrf | ir[7];
                        reent_reg      <= 1'b0;
                        err_sticky_reg <= 1'b0;
                        loop_cnt_reg   <= '0;
                        busy           <= 1'b1;
                    end
                end
                T_RUN: begin
                    if (decide) begin
                        if (repeat_ph) begin
                            loop_cnt_reg <= loop_cnt_reg + LW'(1);
                        end else if (finish) begin
                            state_reg <= T_DONE;
                            phase_reg <= F_NONE;
                            f         <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            err       <= err_sticky_reg | trip;
                        end else begin
                            phase_reg    <= nxt_phase;
                            f            <= phase_bits(nxt_phase);
                            loop_cnt_reg <= '0;
                            if (reenter)
                                reent_reg <= 1'b1;
                            if (trip)
                                err_sticky_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= T_IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_seq.sv
// Directed bench for fp_seq: runs each operation class, records the visited phase trace,
// phase lengths, strobe timing and the done/err pulse, and compares with hand-derived values.
`timescale 1ns/1ps
module tb_fp_seq;

    localparam int STROB_GAP = 1;
    localparam int MAX_LOOP  = 48;

    logic        __clk = 1'b0;
    logic        clr_;
    logic        start;
    logic [7:9]  ir;
    logic        pufa;
    logic        nrf;
    logic        fic;
    logic        nz;
    logic        ws_;
    logic [1:13] f;
    logic        strob_fp_;
    logic        strob2_fp;
    logic        busy;
    logic        done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    fp_seq #(.STROB_GAP(STROB_GAP), .MAX_LOOP(MAX_LOOP)) dut (
        .__clk     (__clk),
        .clr_      (clr_),
        .start     (start),
        .ir        (ir),
        .pufa      (pufa),
        .nrf       (nrf),
        .fic       (fic),
        .nz        (nz),
        .ws_       (ws_),
        .f         (f),
        .strob_fp_ (strob_fp_),
        .strob2_fp (strob2_fp),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 __clk = ~__clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] phase_idx(input logic [1:13] fv);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 1; i <= 13; i++)
            if (fv[i]) idx = 4'(i);
        return idx;
    endfunction

    // Called at a negedge; pulses start, then samples every negedge until done.
    task automatic run_op(input string name, input logic pufa_i, input logic nrf_i,
                          input logic [2:0] ir_i, input int fic_reps, input logic nz_i,
                          input logic ws_i, input int watch, input int ign_cyc,
                          input bit done_start, input logic [63:0] exp_trace,
                          input int exp_done, input int exp_dur, input logic exp_err);
        logic [63:0] trace    = '0;
        logic [1:13] prev_f   = '0;
        int          cyc      = 0;
        int          n6       = 0;
        int          dur      = 0;
        int          s1       = 0;
        int          s2       = 0;
        int          viol     = 0;
        int          done_cyc = 0;
        logic        err_seen = 1'b0;
        bit          finished = 1'b0;

        pufa = pufa_i; nrf = nrf_i; ir = ir_i; nz = nz_i; ws_ = ws_i; fic = 1'b0;
        start = 1'b1;
        while (!finished && cyc < 400) begin
            @(negedge __clk);
            cyc++;
            start = (ign_cyc != 0) && (cyc == ign_cyc);
            if (start) begin
                pufa = 1'b1; nrf = 1'b0; ir = 3'b010;
            end
            if (!strob_fp_ && strob2_fp) viol++;
            if ((f == '0) && (!strob_fp_ || strob2_fp)) viol++;
            if ($countones(f) > 1) viol++;
            if (busy != (f != '0)) viol++;
            if (err && !done) viol++;
            if ((f != '0) && (f != prev_f))
                trace = {trace[59:0], phase_idx(f)};
            prev_f = f;
            if (f[watch]) dur++;
            if (!strob_fp_ && (s1 == 0)) s1 = cyc;
            if (strob2_fp && (s2 == 0)) s2 = cyc;
            if (f[6]) begin
                fic = (n6 < 5 * fic_reps);
                n6++;
            end else begin
                fic = 1'b0;
            end
            if (done) begin
                finished = 1'b1;
                done_cyc = cyc;
                err_seen = err;
            end
        end
        if (!finished) check({name, "/timeout"}, 64'd1, 64'd0);
        if (done_start) start = 1'b1;
        @(negedge __clk);
        start = 1'b0;
        check({name, "/idle_after_done"}, {50'd0, busy, f}, 64'd0);
        check({name, "/trace"}, trace, exp_trace);
        check({name, "/done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({name, "/err"}, 64'(err_seen), 64'(exp_err));
        check({name, "/phase_len"}, 64'(dur), 64'(exp_dur));
        check({name, "/strob_at"}, 64'(s1), 64'd2);
        check({name, "/strob2_at"}, 64'(s2), 64'(3 + STROB_GAP));
        check({name, "/invariants"}, 64'(viol), 64'd0);
        $display("op %-4s trace=%0h done@%0d err=%0b F%0d_len=%0d", name, trace, done_cyc,
                 err_seen, watch, dur);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        clr_ = 1'b0; start = 1'b0; ir = 3'b000; pufa = 1'b0; nrf = 1'b0;
        fic = 1'b0; nz = 1'b0; ws_ = 1'b1;
        repeat (3) @(negedge __clk);
        check("reset/f", 64'(f), 64'd0);
        check("reset/strob_fp_", 64'(strob_fp_), 64'd1);
        check("reset/strob2_fp", 64'(strob2_fp), 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/err", 64'(err), 64'd0);
        clr_ = 1'b1;
        @(negedge __clk);

        //     name    pufa  nrf   ir      fic nz    ws_   watch ign done_st trace            done len err
        run_op("AD",   1'b1, 1'b0, 3'b000, 0, 1'b0, 1'b1, 1,  0, 1'b0, 64'h17A,          16,  5,  1'b0);
        run_op("AD2",  1'b1, 1'b0, 3'b000, 0, 1'b0, 1'b0, 10, 5, 1'b1, 64'h17A,          16,  5,  1'b0);
        run_op("SD",   1'b1, 1'b0, 3'b001, 0, 1'b0, 1'b1, 7,  0, 1'b0, 64'h17A,          16,  5,  1'b0);
        run_op("MW",   1'b1, 1'b0, 3'b010, 3, 1'b0, 1'b1, 6,  0, 1'b0, 64'h12467A,       46,  20, 1'b0);
        run_op("DW",   1'b1, 1'b0, 3'b011, 0, 1'b0, 1'b1, 6,  0, 1'b0, 64'h12467A,       31,  5,  1'b0);
        run_op("AF",   1'b0, 1'b0, 3'b100, 0, 1'b1, 1'b1, 8,  0, 1'b0, 64'h124589AD,     281, 245, 1'b1);
        run_op("MF",   1'b0, 1'b0, 3'b110, 0, 1'b0, 1'b0, 7,  0, 1'b0, 64'h1246789A7AD,  56,  10, 1'b0);
        run_op("NRF",  1'b0, 1'b1, 3'b000, 0, 1'b0, 1'b1, 8,  0, 1'b0, 64'h18AD,         21,  5,  1'b0);
        run_op("DF",   1'b0, 1'b0, 3'b111, 0, 1'b0, 1'b1, 13, 0, 1'b0, 64'h1246789AD,    46,  5,  1'b0);

        // Abort a MW operation during the F4 first strobe.
        pufa = 1'b1; nrf = 1'b0; ir = 3'b010; nz = 1'b0; ws_ = 1'b1; fic = 1'b0;
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge __clk);
            start = 1'b0;
            if (f[4] && !strob_fp_) found = 1'b1;
        end
        check("abort/reach_f4_strob", 64'(found), 64'd1);
        clr_ = 1'b0;
        @(negedge __clk);
        check("abort/f", 64'(f), 64'd0);
        check("abort/strob_fp_", 64'(strob_fp_), 64'd1);
        check("abort/strob2_fp", 64'(strob2_fp), 64'd0);
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/done", 64'(done), 64'd0);
        @(negedge __clk);
        check("abort/no_done", 64'(done), 64'd0);
        $display("op ABRT reset applied in F4 strobe");
        clr_ = 1'b1;
        run_op("AD3",  1'b1, 1'b0, 3'b000, 0, 1'b0, 1'b1, 1,  0, 1'b0, 64'h17A,          16,  5,  1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
